// File: rtl/tetris_pkg.sv
// Shared tetromino definitions: piece codes, widths and small helpers.
package tetris_pkg;

  localparam int unsigned PIECE_W = 3;
  localparam int unsigned COUNT_W = 3;
  localparam int unsigned BAG_W   = 7;

  localparam logic [PIECE_W-1:0] PIECE_I    = 3'd0;
  localparam logic [PIECE_W-1:0] PIECE_O    = 3'd1;
  localparam logic [PIECE_W-1:0] PIECE_T    = 3'd2;
  localparam logic [PIECE_W-1:0] PIECE_S    = 3'd3;
  localparam logic [PIECE_W-1:0] PIECE_Z    = 3'd4;
  localparam logic [PIECE_W-1:0] PIECE_J    = 3'd5;
  localparam logic [PIECE_W-1:0] PIECE_L    = 3'd6;
  localparam logic [PIECE_W-1:0] PIECE_NONE = 3'd7;

  localparam logic [BAG_W-1:0] BAG_FULL = 7'h7F;

  // Generator emits 7 as a filler code that never becomes a piece.
  function automatic logic piece_is_real(input logic [PIECE_W-1:0] code);
    return code != PIECE_NONE;
  endfunction

endpackage

// File: rtl/tetromino_queue_if.sv
// Piece-queue bus: generator/game side (master) and queue side (slave).
interface tetromino_queue_if
  import tetris_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) ();

  localparam int unsigned PREV_W = PIECE_W * (DEPTH - 1);

  logic [PIECE_W-1:0] rand_in;
  logic               pop;
  logic [PIECE_W-1:0] piece;
  logic               piece_valid;
  logic [PREV_W-1:0]  preview;
  logic [COUNT_W-1:0] count;

  modport master (
    output rand_in, pop,
    input  piece, piece_valid, preview, count
  );

  modport slave (
    input  rand_in, pop,
    output piece, piece_valid, preview, count
  );

endinterface

// File: rtl/tetromino_bag.sv
// 7-bag used-piece mask: refuses a code already dealt in the current bag.
module tetromino_bag
  import tetris_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [PIECE_W-1:0] code_i,
  input  logic               commit_i,
  output logic               accept_ok_c
);

  logic [BAG_W-1:0] mask_q, mask_d, set_c;

  // Code 7 shifts out of the 7-bit field, so it never aliases a real bit.
  always_comb begin
    set_c       = BAG_W'(1) << code_i;
    accept_ok_c = piece_is_real(code_i) && ((mask_q & set_c) == '0);
    mask_d      = mask_q;
    if (commit_i) begin
      mask_d = mask_q | set_c;
      if (mask_d == BAG_FULL) begin
        mask_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

endmodule

// File: rtl/tetromino_queue.sv
// Next-piece FIFO behind the tetromino generator with preview export.
// Optional 7-bag dealing enabled by defining TETROMINO_BAG_EN.
module tetromino_queue
  import tetris_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input logic               clk,
  input logic               rst,
  tetromino_queue_if.slave  bus
);

  logic [PIECE_W-1:0] q_q [DEPTH];
  logic [PIECE_W-1:0] q_d [DEPTH];
  logic [COUNT_W-1:0] count_q, count_d;
  logic               valid_q, valid_d;
  logic               eff_pop_c, full_c, push_c, bag_ok_c;

  assign eff_pop_c = bus.pop && (count_q != '0);
  assign full_c    = (count_q == COUNT_W'(DEPTH));
  assign push_c    = piece_is_real(bus.rand_in) && (!full_c || eff_pop_c) && bag_ok_c;

`ifdef TETROMINO_BAG_EN
  tetromino_bag u_bag (
    .clk         (clk),
    .rst         (rst),
    .code_i      (bus.rand_in),
    .commit_i    (push_c),
    .accept_ok_c (bag_ok_c)
  );
`else
  assign bag_ok_c = 1'b1;
`endif

  // Shift on pop; the push lands just past the last valid entry after the shift.
  always_comb begin
    q_d     = q_q;
    count_d = count_q;
    if (eff_pop_c) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
        q_d[i] = q_q[i+1];
      end
      q_d[DEPTH-1] = '0;
      if (push_c) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (COUNT_W'(i) == (count_q - COUNT_W'(1))) begin
            q_d[i] = bus.rand_in;
          end
        end
      end else begin
        count_d = count_q - COUNT_W'(1);
      end
    end else if (push_c) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (COUNT_W'(i) == count_q) begin
          q_d[i] = bus.rand_in;
        end
      end
      count_d = count_q + COUNT_W'(1);
    end
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_q[i] <= '0;
      end
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign bus.piece       = q_q[0];
  assign bus.piece_valid = valid_q;
  assign bus.count       = count_q;

  always_comb begin
    bus.preview = '0;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      bus.preview[PIECE_W*(k-1) +: PIECE_W] = q_q[k];
    end
  end

endmodule

// File: tb/tb_tetromino_queue.sv
// Scoreboard bench for tetromino_queue: queue-based reference model, random and directed stimulus.
module tb_tetromino_queue;
  import tetris_pkg::*;

  localparam int unsigned DEPTH = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  tetromino_queue_if #(.DEPTH(DEPTH)) bus ();

  tetromino_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int piece;
    int valid;
    int preview;
    int count;
  } exp_t;

  exp_t exp_q[$];
  int   mdl[$];
  bit   used[7];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  function automatic exp_t model_view();
    exp_t e;
    e.count   = mdl.size();
    e.valid   = (mdl.size() != 0) ? 1 : 0;
    e.piece   = (mdl.size() != 0) ? mdl[0] : 0;
    e.preview = 0;
    for (int k = 1; k < mdl.size(); k++) e.preview += mdl[k] << (3 * (k - 1));
    return e;
  endfunction

  function automatic void model_step(input int r, input bit p);
    bit ep;
    bit ok;
    int n;
    ep = p && (mdl.size() > 0);
    ok = (r != 7) && ((mdl.size() < DEPTH) || ep);
`ifdef TETROMINO_BAG_EN
    if (r != 7 && used[r]) ok = 1'b0;
`endif
    if (ep) void'(mdl.pop_front());
    if (ok) begin
      mdl.push_back(r);
`ifdef TETROMINO_BAG_EN
      used[r] = 1'b1;
      n = 0;
      foreach (used[i]) n += int'(used[i]);
      if (n == 7) used = '{default: 1'b0};
`endif
    end
    n = 0;
  endfunction

  // Inputs change mid-cycle; expectation is for the state after the next rising edge.
  task automatic step(input int r, input bit p, input bit rst_v);
    @(negedge clk);
    #1;
    rst         = rst_v;
    bus.rand_in = 3'(r);
    bus.pop     = p;
    if (!rst_v) begin
      mdl.delete();
      used = '{default: 1'b0};
    end else begin
      model_step(r, p);
    end
    exp_q.push_back(model_view());
  endtask

  task automatic async_reset();
    @(negedge clk);
    #1;
    rst         = 1'b0;
    bus.rand_in = 3'd7;
    bus.pop     = 1'b0;
    mdl.delete();
    used = '{default: 1'b0};
    #1;
    chk("async_piece",   int'(bus.piece),       0);
    chk("async_valid",   int'(bus.piece_valid), 0);
    chk("async_preview", int'(bus.preview),     0);
    chk("async_count",   int'(bus.count),       0);
    exp_q.push_back(model_view());
  endtask

  // Monitor: compare DUT outputs with the oldest pending expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("piece",   int'(bus.piece),       e.piece);
        chk("valid",   int'(bus.piece_valid), e.valid);
        chk("preview", int'(bus.preview),     e.preview);
        chk("count",   int'(bus.count),       e.count);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int bag_seq[9];
    bag_seq = '{0, 0, 1, 2, 3, 4, 5, 6, 0};
    bus.rand_in = 3'd7;
    bus.pop     = 1'b0;

    repeat (3) step(7, 1'b0, 1'b0);
    repeat (10) step(7, 1'b0, 1'b1);

    step(3, 1'b0, 1'b1);
    step(5, 1'b0, 1'b1);
    step(1, 1'b0, 1'b1);
    step(2, 1'b0, 1'b1);
    step(6, 1'b1, 1'b1);
    repeat (6) step(7, 1'b1, 1'b1);

    step(7, 1'b0, 1'b0);
    foreach (bag_seq[i]) step(bag_seq[i], 1'b1, 1'b1);
    step(7, 1'b0, 1'b1);

    step(3, 1'b0, 1'b1);
    step(5, 1'b0, 1'b1);
    async_reset();
    step(7, 1'b0, 1'b0);
    step(4, 1'b0, 1'b1);
    step(6, 1'b0, 1'b1);

    repeat (400) step(int'($urandom_range(0, 7)), ($urandom_range(0, 9) < 4), 1'b1);

    repeat (2) @(negedge clk);
    #2;
    chk("drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
